// File: rtl/mont_mul.sv
// Word-serial Montgomery multiplier: result = a*b*2^-N mod n.
// One word of a is processed per MUL/RED pair, then a final conditional subtract.
module mont_mul #(
    parameter int N = 256,
    parameter int V = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] n,
    input  logic [V-1:0] n_prime,
    output logic [N-1:0] result,
    output logic         busy,
    output logic         done
);
    localparam int W  = N / V;
    localparam int TW = N + V + 2;
    localparam int SW = TW + 1;
    localparam int IW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_RED, S_SUB} state_t;

    state_t         r_state;
    state_t         w_next;
    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    logic [N-1:0]   r_n;
    logic [V-1:0]   r_np;
    logic [TW-1:0]  r_t;
    logic [IW-1:0]  r_i;
    logic [N-1:0]   r_result;
    logic           r_done;

    logic [V-1:0]   w_a_word;
    logic [TW-1:0]  w_mul;
    logic [V-1:0]   w_m;
    logic [SW-1:0]  w_red_sum;
    logic [TW-1:0]  w_red;
    logic           w_ge;
    logic [TW-1:0]  w_sub;
    logic           w_last;

    assign w_a_word  = r_a[r_i*V +: V];
    assign w_mul     = r_t + TW'(w_a_word) * TW'(r_b);
    assign w_m       = V'(r_t[V-1:0] * r_np);
    // Low V bits of the sum are zero, so the shift is an exact division by 2^V.
    assign w_red_sum = SW'(r_t) + SW'(w_m) * SW'(r_n);
    assign w_red     = TW'(w_red_sum >> V);
    assign w_ge      = (r_t >= TW'(r_n));
    assign w_sub     = r_t - TW'(r_n);
    assign w_last    = (r_i == IW'(W - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_MUL;
            S_MUL:   w_next = S_RED;
            S_RED:   w_next = w_last ? S_SUB : S_MUL;
            S_SUB:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_n      <= '0;
            r_np     <= '0;
            r_t      <= '0;
            r_i      <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == S_SUB);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a  <= a;
                        r_b  <= b;
                        r_n  <= n;
                        r_np <= n_prime;
                        r_t  <= '0;
                        r_i  <= '0;
                    end
                end
                S_MUL: r_t <= w_mul;
                S_RED: begin
                    r_t <= w_red;
                    r_i <= r_i + 1'b1;
                end
                S_SUB: r_result <= w_ge ? N'(w_sub) : N'(r_t);
                default: ;
            endcase
        end
    end

    assign result = r_result;
    assign busy   = (r_state != S_IDLE);
    assign done   = r_done;
endmodule
